// File: rtl/display_page_scheduler.sv
// display_page_scheduler: arbitrates the dashboard right-hand field between the
// normal speed page, the rotating OBD pages and prioritised vehicle warnings,
// and produces the warning blink/blank control for the display driver.
module display_page_scheduler #(
  parameter int unsigned ROTATE_TICKS = 30,
  parameter int unsigned WARN_HOLD    = 20,
  parameter int unsigned BLINK_HALF   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       obd_mode_sw,
  input  logic       page_btn,
  input  logic       warn_ack,
  input  logic [2:0] warn_req,
  output logic [2:0] page_sel,
  output logic [1:0] warn_id,
  output logic       blank_right,
  output logic       warn_active
);

  localparam int unsigned RW = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  localparam int unsigned HW = $clog2(WARN_HOLD + 1);
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_OBD    = 2'd1;
  localparam logic [1:0] ST_WARN   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          obd_two, obd_two_nxt;     // 0 = OBD page 1, 1 = OBD page 2
  logic [RW-1:0] rot_cnt, rot_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_on, blink_on_nxt;
  logic [2:0]    mask, mask_nxt;
  logic [1:0]    warn_id_nxt;
  logic [2:0]    page_sel_nxt;
  logic          blank_right_nxt;
  logic          warn_active_nxt;

  logic [2:0]    pend;
  logic [2:0]    rest;
  logic [2:0]    cur_bit;
  logic [2:0]    mask_set;
  logic [1:0]    win;
  logic [1:0]    restart_id;
  logic          restart;
  logic          hold_done;

  // Highest-priority pending warning code: overheat, then overspeed, then low fuel
  function automatic logic [1:0] pick(input logic [2:0] p);
    if (p[1])      return 2'd2;
    else if (p[2]) return 2'd3;
    else if (p[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Priority rank of a warning code (larger wins, 0 = no warning)
  function automatic logic [1:0] rank(input logic [1:0] code);
    case (code)
      2'd2:    return 2'd3;
      2'd3:    return 2'd2;
      2'd1:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Request bit that a warning code stands for
  function automatic logic [2:0] code_bit(input logic [1:0] code);
    case (code)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Next-state, counter and output decode
  always_comb begin
    state_nxt     = state;
    obd_two_nxt   = obd_two;
    rot_cnt_nxt   = rot_cnt;
    hold_cnt_nxt  = hold_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    warn_id_nxt   = warn_id;
    mask_set      = 3'b000;
    restart       = 1'b0;
    restart_id    = 2'd0;
    rest          = 3'b000;

    pend      = warn_req & ~mask;
    win       = pick(pend);
    cur_bit   = code_bit(warn_id);
    hold_done = (hold_cnt == HW'(WARN_HOLD));

    case (state)
      ST_NORMAL: begin
        if (pend != 3'b000) begin
          restart    = 1'b1;
          restart_id = win;
        end else if (obd_mode_sw) begin
          state_nxt   = ST_OBD;
          obd_two_nxt = 1'b0;
          rot_cnt_nxt = '0;
        end
      end
      ST_OBD: begin
        if (pend != 3'b000) begin
          restart    = 1'b1;
          restart_id = win;
        end else if (!obd_mode_sw) begin
          state_nxt = ST_NORMAL;
        end else if (page_btn) begin
          // manual advance takes precedence over a coincident rotate tick
          obd_two_nxt = ~obd_two;
          rot_cnt_nxt = '0;
        end else if (tick_100ms) begin
          if (rot_cnt == RW'(ROTATE_TICKS - 1)) begin
            obd_two_nxt = ~obd_two;
            rot_cnt_nxt = '0;
          end else begin
            rot_cnt_nxt = rot_cnt + RW'(1);
          end
        end
      end
      ST_WARN: begin
        if (rank(win) > rank(warn_id)) begin
          restart    = 1'b1;
          restart_id = win;
        end else begin
          if (warn_ack && hold_done) mask_set = cur_bit;
          if (hold_done && (((warn_req & cur_bit) == 3'b000) || warn_ack)) begin
            rest = pend & ~cur_bit;
            if (rest != 3'b000) begin
              restart    = 1'b1;
              restart_id = pick(rest);
            end else begin
              state_nxt   = obd_mode_sw ? ST_OBD : ST_NORMAL;
              warn_id_nxt = 2'd0;
              rot_cnt_nxt = '0;
            end
          end else if (tick_100ms) begin
            if (!hold_done) hold_cnt_nxt = hold_cnt + HW'(1);
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
              blink_cnt_nxt = '0;
              blink_on_nxt  = ~blink_on;
            end else begin
              blink_cnt_nxt = blink_cnt + BW'(1);
            end
          end
        end
      end
      default: state_nxt = ST_NORMAL;
    endcase

    if (restart) begin
      state_nxt     = ST_WARN;
      warn_id_nxt   = restart_id;
      hold_cnt_nxt  = '0;
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end

    mask_nxt = (mask | mask_set) & warn_req;

    if (state_nxt == ST_WARN)     page_sel_nxt = 3'd4;
    else if (state_nxt == ST_OBD) page_sel_nxt = obd_two_nxt ? 3'd2 : 3'd1;
    else                          page_sel_nxt = 3'd0;
    blank_right_nxt = (state_nxt == ST_WARN) && !blink_on_nxt;
    warn_active_nxt = (state_nxt == ST_WARN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_NORMAL;
      obd_two     <= 1'b0;
      rot_cnt     <= '0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      mask        <= 3'b000;
      warn_id     <= 2'd0;
      page_sel    <= 3'd0;
      blank_right <= 1'b0;
      warn_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      obd_two     <= obd_two_nxt;
      rot_cnt     <= rot_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_on    <= blink_on_nxt;
      mask        <= mask_nxt;
      warn_id     <= warn_id_nxt;
      page_sel    <= page_sel_nxt;
      blank_right <= blank_right_nxt;
      warn_active <= warn_active_nxt;
    end
  end

endmodule

// File: tb/tb_display_page_scheduler.sv
// tb_display_page_scheduler: directed and randomized stimulus for the display
// page scheduler, checked every cycle against a behavioural reference model.
module tb_display_page_scheduler;

  localparam int unsigned ROTATE_TICKS = 30;
  localparam int unsigned WARN_HOLD    = 20;
  localparam int unsigned BLINK_HALF   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100ms = 1'b0;
  logic       obd_mode_sw = 1'b0;
  logic       page_btn = 1'b0;
  logic       warn_ack = 1'b0;
  logic [2:0] warn_req = 3'b000;
  logic [2:0] page_sel;
  logic [1:0] warn_id;
  logic       blank_right;
  logic       warn_active;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_cur is the displayed warning code (0 = none), m_ticks the
  // ticks seen since that warning was (re)started, m_obd/m_page the page mode.
  int       m_cur, m_ticks, m_obd, m_page, m_rot;
  bit [2:0] m_mask;

  display_page_scheduler #(
    .ROTATE_TICKS(ROTATE_TICKS),
    .WARN_HOLD(WARN_HOLD),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_100ms(tick_100ms),
    .obd_mode_sw(obd_mode_sw),
    .page_btn(page_btn),
    .warn_ack(warn_ack),
    .warn_req(warn_req),
    .page_sel(page_sel),
    .warn_id(warn_id),
    .blank_right(blank_right),
    .warn_active(warn_active)
  );

  always #5 clk = ~clk;

  function automatic int win_of(input bit [2:0] p);
    int order_bit[3];
    int order_code[3];
    order_bit  = '{1, 2, 0};
    order_code = '{2, 3, 1};
    for (int i = 0; i < 3; i++)
      if (p[order_bit[i]]) return order_code[i];
    return 0;
  endfunction

  function automatic int rank_of(input int c);
    if (c == 2) return 3;
    if (c == 3) return 2;
    if (c == 1) return 1;
    return 0;
  endfunction

  function automatic int bit_of(input int c);
    if (c == 2) return 1;
    if (c == 3) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_ticks = 0; m_obd = 0; m_page = 1; m_rot = 0; m_mask = 3'b000;
  endtask

  task automatic model_enter(input int c);
    m_cur = c;
    m_ticks = 0;
  endtask

  // One clock of the reference behaviour, using the inputs currently driven
  task automatic model_step();
    bit [2:0] req, pend, set_m, rest;
    int w, b;
    bit done;
    req   = warn_req;
    pend  = req & ~m_mask;
    set_m = 3'b000;
    w     = win_of(pend);
    if (m_cur == 0) begin
      if (pend != 0) model_enter(w);
      else if (m_obd == 0) begin
        if (obd_mode_sw) begin m_obd = 1; m_page = 1; m_rot = 0; end
      end else if (!obd_mode_sw) m_obd = 0;
      else if (page_btn) begin m_page = 3 - m_page; m_rot = 0; end
      else if (tick_100ms) begin
        m_rot++;
        if (m_rot == ROTATE_TICKS) begin m_page = 3 - m_page; m_rot = 0; end
      end
    end else if (rank_of(w) > rank_of(m_cur)) begin
      model_enter(w);
    end else begin
      done = (m_ticks >= WARN_HOLD);
      b = bit_of(m_cur);
      if (done && warn_ack) set_m[b] = 1'b1;
      if (done && (!req[b] || warn_ack)) begin
        rest = pend;
        rest[b] = 1'b0;
        if (rest != 0) model_enter(win_of(rest));
        else begin m_cur = 0; m_obd = obd_mode_sw ? 1 : 0; m_rot = 0; end
      end else if (tick_100ms) m_ticks++;
    end
    m_mask = (m_mask | set_m) & req;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int ep;
    ep = (m_cur != 0) ? 4 : (m_obd != 0 ? m_page : 0);
    check("page_sel", 4'(page_sel), 4'(ep));
    check("warn_id", 4'(warn_id), 4'(m_cur));
    check("blank_right", 4'(blank_right),
          4'((m_cur != 0 && ((m_ticks / BLINK_HALF) % 2) == 1) ? 1 : 0));
    check("warn_active", 4'(warn_active), 4'(m_cur != 0 ? 1 : 0));
  endtask

  // Apply one cycle of pulse inputs, advance model and DUT, then compare
  task automatic cyc(input bit t, input bit b, input bit a);
    tick_100ms = t; page_btn = b; warn_ack = a;
    model_step();
    @(posedge clk);
    #1;
    tick_100ms = 1'b0; page_btn = 1'b0; warn_ack = 1'b0;
    check_all();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // OBD rotation, manual advance, then button coincident with the rotate tick
    obd_mode_sw = 1'b1;
    cyc(0, 0, 0);
    run_ticks(30);
    run_ticks(10);
    cyc(0, 1, 0);
    run_ticks(ROTATE_TICKS - 1);
    cyc(1, 1, 0);
    run_ticks(5);

    // Short low-fuel request held on screen for the full hold time
    obd_mode_sw = 1'b0;
    cyc(0, 0, 0);
    warn_req = 3'b001;
    run_ticks(5);
    warn_req = 3'b000;
    run_ticks(22);

    // Overheat preempts low fuel; early ack ignored, late ack falls back to low fuel
    warn_req = 3'b001;
    run_ticks(8);
    warn_req = 3'b011;
    run_ticks(2);
    cyc(0, 0, 1);
    run_ticks(20);
    cyc(0, 0, 1);
    run_ticks(22);
    cyc(0, 0, 1);
    warn_req = 3'b000;
    run_ticks(2);

    // Overspeed acked while still requested, page button ignored during warning
    obd_mode_sw = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    warn_req = 3'b100;
    run_ticks(3);
    cyc(0, 1, 0);
    run_ticks(20);
    cyc(0, 0, 1);
    run_ticks(3);
    warn_req = 3'b000;
    cyc(0, 0, 0);
    warn_req = 3'b100;
    run_ticks(4);

    // Reset in the middle of an overheat warning
    warn_req = 3'b010;
    run_ticks(6);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    cyc(0, 0, 0);
    run_ticks(3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) warn_req = 3'($urandom_range(7, 0));
      if ($urandom_range(199, 0) == 0) obd_mode_sw = ~obd_mode_sw;
      cyc($urandom_range(2, 0) == 0, $urandom_range(19, 0) == 0,
          $urandom_range(14, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
